mem_access_unit: RTL and testbench

//  MAR/MDR memory-access stage directly downstream of the program counter.
//  The PC is gated onto the bus and latched into MAR; this block then runs the

---
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit.sv | 98 +++++++++
 tb/tb_mem_access_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory-side request/acknowledge bus of the MAR/MDR access stage.
// The stage is the master; the memory (or its model) is the slave.
interface mem_access_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // mem_req rises with stable addr/we/wdata and stays high until the cycle
    // after mem_ack is seen (or the wait is abandoned); mem_ack is a one-cycle
    // pulse, and mem_rdata is only meaningful in that cycle.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access stage: latches the address, runs one memory request
// per mio_en, and raises r for the control FSM when the data is in hand.
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              rw,
    input  logic              gate_mdr,
    output logic [DATA_W-1:0] mdr_to_bus,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              r,
    output logic              mem_err,
    output logic [1:0]        state,
    mem_access_unit_if.master mem
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rdata_q;

    assign mdr_to_bus = gate_mdr ? mdr : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mar           <= '0;
            mdr           <= '0;
            r             <= 1'b0;
            mem_err       <= 1'b0;
            count         <= '0;
            rdata_q       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mio_en) begin
                        state         <= S_BUSY;
                        mem.mem_req   <= 1'b1;
                        mem.mem_addr  <= mar;
                        mem.mem_we    <= rw;
                        mem.mem_wdata <= mdr;
                    end
                end
                S_BUSY: begin
                    // An ack arriving on the final allowed cycle still counts as success.
                    if (mem.mem_ack) begin
                        state       <= S_DONE;
                        mem.mem_req <= 1'b0;
                        r           <= 1'b1;
                        if (!mem.mem_we) rdata_q <= mem.mem_rdata;
                    end else if (count == CNT_END) begin
                        state       <= S_DONE;
                        mem.mem_req <= 1'b0;
                        r           <= 1'b1;
                        rdata_q     <= '0;
                        mem_err     <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!mio_en) begin
                        state <= S_IDLE;
                        r     <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (state == S_IDLE && ld_mar) mar <= ADDR_W'(bus_in);

            // MDR takes the bus only while idle; read data only once the read is done.
            if (ld_mdr) begin
                if (!mio_en && state == S_IDLE)
                    mdr <= bus_in;
                else if (mio_en && !rw && state == S_DONE)
                    mdr <= rdata_q;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: each transaction queues its expected address and
// data, and the queue is drained as the request and result appear.
module tb_mem_access_unit;
    localparam int TO = 4;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, rw, gate_mdr;
    wire  [15:0] mdr_to_bus;
    logic [15:0] mar, mdr;
    logic        r, mem_err;
    logic [1:0]  dbg_state;

    logic [15:0] exp_q[$];
    logic        model_err;
    int          n_checks = 0;
    int          n_pass   = 0;

    mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) mif ();

    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .ld_mar     (ld_mar),
        .ld_mdr     (ld_mdr),
        .mio_en     (mio_en),
        .rw         (rw),
        .gate_mdr   (gate_mdr),
        .mdr_to_bus (mdr_to_bus),
        .mar        (mar),
        .mdr        (mdr),
        .r          (r),
        .mem_err    (mem_err),
        .state      (dbg_state),
        .mem        (mif.master)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [15:0] addr, input logic rw_i, input logic [15:0] data,
                           input int wait_cyc, input bit ack_it, input bit poke_mar);
        int          n;
        logic [15:0] e;
        bus_in = addr; ld_mar = 1'b1; step(); ld_mar = 1'b0;
        if (rw_i) begin
            bus_in = data; ld_mdr = 1'b1; step(); ld_mdr = 1'b0;
        end
        exp_q.push_back(addr);
        exp_q.push_back((ack_it || rw_i) ? data : 16'h0000);
        if (!ack_it) model_err = 1'b1;

        mio_en = 1'b1; rw = rw_i; step();
        check("req_on", mif.mem_req, 1'b1);
        check("busy_state", dbg_state, BUSY);
        check("r_low_busy", r, 1'b0);
        e = exp_q.pop_front();
        check("mem_addr", mif.mem_addr, e);
        check("mem_we", mif.mem_we, rw_i);
        if (rw_i) begin
            e = exp_q.pop_front();
            check("mem_wdata", mif.mem_wdata, e);
        end
        if (poke_mar) begin
            bus_in = 16'h5555; ld_mar = 1'b1; step(); ld_mar = 1'b0;
            check("mar_blocked", mar, addr);
            check("addr_stable", mif.mem_addr, addr);
        end

        n = 0;
        if (ack_it) begin
            repeat (wait_cyc - int'(poke_mar)) step();
            mif.mem_ack = 1'b1;
            mif.mem_rdata = rw_i ? 16'hDEAD : data;
            step();
            mif.mem_ack = 1'b0;
            mif.mem_rdata = 16'($urandom);
        end else begin
            while (!r && n < 40) begin
                step();
                n++;
            end
            check("timeout_len", int'(poke_mar) + n, TO);
        end
        check("r_done", r, 1'b1);
        check("req_dropped", mif.mem_req, 1'b0);
        check("done_state", dbg_state, DONE);

        ld_mdr = 1'b1; step(); ld_mdr = 1'b0;
        if (!rw_i) begin
            e = exp_q.pop_front();
            check("mdr_read", mdr, e);
        end else begin
            check("mdr_kept", mdr, data);
        end
        check("mem_err", mem_err, model_err);
        check("r_held", r, 1'b1);

        mio_en = 1'b0; step();
        check("r_clear", r, 1'b0);
        check("idle_state", dbg_state, IDLE);
    endtask

    initial begin
        rst_n = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; rw = 0; gate_mdr = 0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0; model_err = 1'b0;

        // T1 reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("rst_mar", mar, 16'h0);
        check("rst_mdr", mdr, 16'h0);
        check("rst_r", r, 1'b0);
        check("rst_req", mif.mem_req, 1'b0);
        check("rst_err", mem_err, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_hiz", 32'(mdr_to_bus === 16'hzzzz), 32'd1);

        // T2 fetch, two wait cycles
        run_txn(16'h3000, 1'b0, 16'h1234, 2, 1'b1, 1'b0);
        gate_mdr = 1'b1; #1;
        check("gate_on", mdr_to_bus, 16'h1234);
        gate_mdr = 1'b0; #1;
        check("gate_off", 32'(mdr_to_bus === 16'hzzzz), 32'd1);

        // T3 store
        run_txn(16'h4000, 1'b1, 16'hBEEF, 1, 1'b1, 1'b0);
        // zero-wait read and an ack on the last allowed cycle
        run_txn(16'h0042, 1'b0, 16'hA5A5, 0, 1'b1, 1'b0);
        run_txn(16'h0043, 1'b0, 16'h5A5A, TO - 1, 1'b1, 1'b0);
        // T5 MAR blocked while busy
        run_txn(16'h6000, 1'b0, 16'h7777, 2, 1'b1, 1'b1);
        // T4 timeout, then sticky error over good traffic
        run_txn(16'h7000, 1'b0, 16'h9999, 0, 1'b0, 1'b1);
        run_txn(16'h7100, 1'b1, 16'hC0DE, 0, 1'b1, 1'b0);
        run_txn(16'h7200, 1'b1, 16'hFACE, 0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++)
            run_txn(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                    $urandom_range(0, TO - 1), 1'b1, 1'b0);

        // T6 reset while busy, late ack ignored
        bus_in = 16'h8000; ld_mar = 1'b1; step(); ld_mar = 1'b0;
        mio_en = 1'b1; rw = 1'b0; step();
        check("abort_req_on", mif.mem_req, 1'b1);
        rst_n = 1'b0; step(); rst_n = 1'b1; mio_en = 1'b0;
        model_err = 1'b0;
        check("abort_req", mif.mem_req, 1'b0);
        check("abort_state", dbg_state, IDLE);
        check("abort_err", mem_err, model_err);
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'hFFFF; step(); mif.mem_ack = 1'b0;
        check("late_ack_state", dbg_state, IDLE);
        check("late_ack_r", r, 1'b0);
        check("late_ack_mdr", mdr, 16'h0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
